// File: rtl/fifo_syn_ext.sv
// Single-clock synchronous FIFO with programmable almost-full/almost-empty
// thresholds, optional show-ahead reads, error pulses and an exact occupancy count.
module fifo_syn_ext #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2,
  parameter int SHOWAHEAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      usedw,
  output logic             overflow,
  output logic             underflow
);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AE_LEVEL >= AF_LEVEL) ||
      (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) || (AE_LEVEL < 0)) begin : g_param_bad
    $error("fifo_syn_ext: illegal DEPTH / AF_LEVEL / AE_LEVEL combination");
  end

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             rd_ok;
  logic             wr_ok;

  // Handshake: a request is taken at the rising edge where it is high and
  // accepted. A read is accepted only when not empty; a write only when not
  // full, or when full but a read is accepted in the same cycle. Rejected
  // requests leave all state untouched and raise a one-cycle error pulse.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  assign usedw        = count;
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & ~wr_ok;
      underflow <= rd & ~rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    // Head entry is visible directly; stable at the last head while empty.
    assign q = mem[rd_ptr];
  end else begin : g_normal
    logic [WIDTH-1:0] q_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        q_reg <= '0;
      end else if (rd_ok) begin
        q_reg <= mem[rd_ptr];
      end
    end
    assign q = q_reg;
  end

endmodule

// File: doc/fifo_syn_ext.md
Name: fifo_syn_ext

Overview:
Parametrised single-clock synchronous FIFO. It is the next generation of the team's basic fifo_syn and adds:
- generic width and depth
- programmable almost-full and almost-empty thresholds
- a selectable show-ahead read mode
- sticky-free overflow and underflow error pulses
- an exact occupancy count covering 0..DEPTH

It sits between producer and consumer blocks in the same clock domain and replaces fifo_syn wherever thresholds or first-word fall-through reads are needed.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries. Must be a power of two and at least 4.
- AW, $clog2(DEPTH), pointer width. Derived; not overridden.
- AF_LEVEL, DEPTH-2, almost_full asserts when usedw >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when usedw <= AE_LEVEL. Legal range 0..DEPTH-1.
- SHOWAHEAD, 0, read mode.
  - 0 = normal: q is registered and updates 1 cycle after a read.
  - 1 = first-word fall-through: q shows the head entry whenever empty=0.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- wr  input  1  write request.
- rd  input  1  read request.
- data  input  WIDTH  write data.
- q  output  WIDTH  read data.
- full  output  1  usedw == DEPTH.
- empty  output  1  usedw == 0.
- almost_full  output  1  usedw >= AF_LEVEL.
- almost_empty  output  1  usedw <= AE_LEVEL.
- usedw  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is rejected.
- underflow  output  1  one-cycle pulse when a read is rejected.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - wr_ptr, rd_ptr and count are cleared to 0.
  - Outputs after reset: usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, q=0.
  - Memory contents are not cleared.
  - Reset has priority over wr and rd in the same cycle; any in-flight data is discarded.
- Storage and pointers:
  - Storage is a DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are AW bits wide and wrap naturally from DEPTH-1 to 0.
  - A separate (AW+1)-bit count register drives usedw.
- Acceptance rules, evaluated in the same cycle:
  - rd_ok = rd & ~empty.
  - wr_ok = wr & (~full | rd_ok). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
  - When empty, there is no write-to-read bypass: wr and rd together store the word and reject the read.
- Updates on each accepted operation:
  - wr_ok: mem[wr_ptr] <= data; wr_ptr increments.
  - rd_ok: rd_ptr increments.
  - count: +1 when only wr_ok, -1 when only rd_ok, unchanged when both or neither.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational compares on the registered count, so they change in the cycle after the causing edge.
- Error pulses:
  - overflow <= wr & ~wr_ok. Registered; high for exactly 1 cycle per rejected write.
  - underflow <= rd & ~rd_ok. Registered; same behaviour.
  - The FIFO state is unchanged by any rejected operation.
- Read data, SHOWAHEAD=0:
  - On rd_ok, q <= mem[rd_ptr], so data is valid in the cycle after the accepting edge.
  - q holds its value when no read is accepted, including while empty.
- Read data, SHOWAHEAD=1:
  - q = mem[rd_ptr] combinationally. It is valid while empty=0 and is undefined-but-stable (last head location) while empty=1.
  - An accepted rd advances to the next entry at the following edge.
  - The first word written into an empty FIFO appears on q one cycle after the write edge, together with empty falling.
- Wrap-around:
  - Continuous simultaneous wr/rd at any occupancy keeps usedw constant with no data loss across pointer wrap.
- Parameter checks:
  - An elaboration-time check fails if DEPTH is not a power of two or if AE_LEVEL >= AF_LEVEL.

Test Plan (defaults WIDTH=8, DEPTH=16, AF=14, AE=2 unless stated):
1. Fill/drain, SHOWAHEAD=0: rst high 2 cycles, then write 0x01..0x10 on 16 consecutive cycles.
   - Expect usedw=16, full=1, almost_full from usedw=14.
   - A 17th write with rd=0 gives overflow=1 for 1 cycle and usedw stays 16.
   - Then 16 reads return q=0x01..0x10 in order, each 1 cycle after its rd, and empty=1 at the end.
2. Underflow: with the FIFO empty, rd=1 for 3 cycles.
   - Expect underflow high for 3 cycles, usedw=0, q unchanged.
   - wr=1 and rd=1 together while empty with data=0xAB: write accepted, underflow=1, usedw=1.
3. Full with simultaneous rd+wr: fill to 16, then apply wr=1, rd=1, data=0x5A.
   - Expect overflow=0, usedw=16, q=head entry.
   - 0x5A appears as the 16th read afterwards.
4. Wrap-around: hold occupancy at 5 and run 40 cycles of simultaneous wr/rd with incrementing data.
   - Expect usedw=5 throughout and read data to be the exact sequence written 5 words earlier.
5. SHOWAHEAD=1: write 0xAB into an empty FIFO.
   - Expect q=0xAB and empty=0 on the next cycle with no rd.
   - rd=1 for 1 cycle: q switches to the next entry (or empty=1) after the edge.
6. Reset mid-operation: at usedw=9, assert rst for 1 cycle while wr=1 and rd=1.
   - Expect usedw=0, empty=1, almost_empty=1, q=0, no overflow or underflow pulse.
   - The next write/read of 0x77 round-trips correctly.
